// File: rtl/simt_warp_scheduler.sv
// SIMT warp scheduler: shared PC and active mask, with a reconvergence stack for branch divergence.
// Define SCHED_PERF_EN to build the stall and divergence performance counters.

module simt_warp_lane (
    input  logic       i_active,
    input  logic [1:0] i_lsu_state,
    input  logic [2:0] i_alu_nzp,
    input  logic [2:0] i_branch_nzp,
    output logic       o_taken,
    output logic       o_stall
);
    assign o_taken = i_active && |(i_alu_nzp & i_branch_nzp);
    assign o_stall = i_active && (i_lsu_state == 2'b01 || i_lsu_state == 2'b10);
endmodule

module simt_warp_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int STACK_DEPTH       = 8,
    parameter int PC_WIDTH          = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK+1)-1:0] thread_count,
    input  logic                                   decoded_mem_read_enable,
    input  logic                                   decoded_mem_write_enable,
    input  logic                                   decoded_ret,
    input  logic                                   decoded_pc_mux,
    input  logic                                   decoded_barrier_enable,
    input  logic [2:0]                             decoded_nzp,
    input  logic [PC_WIDTH-1:0]                    decoded_immediate,
    input  logic [PC_WIDTH-1:0]                    decoded_reconv_pc,
    input  logic [2:0]                             fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
    input  logic [3*THREADS_PER_BLOCK-1:0]         alu_nzp,
    input  logic [PC_WIDTH-1:0]                    next_pc,
    output logic [PC_WIDTH-1:0]                    current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           active_mask,
    output logic [2:0]                             core_state,
    output logic                                   done,
    output logic                                   fault,
    output logic [1:0]                             fault_code,
    output logic [31:0]                            perf_stall_cycles,
    output logic [15:0]                            perf_divergences
);
    localparam int T    = THREADS_PER_BLOCK;
    localparam int TCW  = $clog2(THREADS_PER_BLOCK+1);
    localparam int SPW  = $clog2(STACK_DEPTH+1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
        S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] reconv_pc;
        logic [PC_WIDTH-1:0] pending_pc;
        logic [T-1:0]        pending_mask;
        logic [T-1:0]        full_mask;
        logic                phase;
    } stk_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, w_new_pc;
    logic [T-1:0]        r_mask, w_mask_nxt, r_launch_mask, w_launch_nxt, w_launch;
    logic [T-1:0]        w_taken, w_stall_lane;
    logic                r_done, w_done_nxt, r_fault, w_fault_nxt;
    logic [1:0]          r_fault_code, w_code_nxt;
    logic [SPW-1:0]      r_sp, w_tos_idx;
    stk_t                r_stack [STACK_DEPTH];
    stk_t                w_tos, w_push_ent;
    logic                w_push, w_pop, w_set_phase, w_start_acc, w_stall, w_mixed;
    logic                w_unused;

    // Memory-op flags are informational: the LSU state alone decides the stall.
    assign w_unused = &{1'b0, decoded_mem_read_enable, decoded_mem_write_enable};

    for (genvar i = 0; i < T; i++) begin : g_lane
        assign w_launch[i] = (thread_count > TCW'(i));
        simt_warp_lane u_lane (
            .i_active     (r_mask[i]),
            .i_lsu_state  (lsu_state[2*i+1:2*i]),
            .i_alu_nzp    (alu_nzp[3*i+2:3*i]),
            .i_branch_nzp (decoded_nzp),
            .o_taken      (w_taken[i]),
            .o_stall      (w_stall_lane[i])
        );
    end

    assign w_stall    = |w_stall_lane;
    assign w_mixed    = decoded_pc_mux && (w_taken != '0) && (w_taken != r_mask);
    assign w_new_pc   = (decoded_pc_mux && (w_taken != '0)) ? decoded_immediate : next_pc;
    assign w_tos_idx  = r_sp - 1'b1;
    assign w_tos      = r_stack[w_tos_idx[IDXW-1:0]];
    assign w_push_ent = '{reconv_pc: decoded_reconv_pc, pending_pc: next_pc,
                          pending_mask: r_mask & ~w_taken, full_mask: r_mask, phase: 1'b0};

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_mask_nxt   = r_mask;
        w_launch_nxt = r_launch_mask;
        w_done_nxt   = r_done;
        w_fault_nxt  = r_fault;
        w_code_nxt   = r_fault_code;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_phase  = 1'b0;
        w_start_acc  = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_start_acc  = 1'b1;
                w_launch_nxt = w_launch;
                if (thread_count == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_mask_nxt  = w_launch;
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH:   if (fetcher_state == 3'b010) w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_REQUEST;
            S_REQUEST: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (decoded_barrier_enable && (r_mask != r_launch_mask)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                    w_code_nxt  = 2'd2;
                end else if (!w_stall) begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: w_state_nxt = S_UPDATE;
            S_UPDATE: begin
                if (decoded_ret || (w_mixed && r_sp == SP_FULL)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    if (decoded_ret && r_sp != '0) begin
                        w_fault_nxt = 1'b1;
                        w_code_nxt  = 2'd3;
                    end else if (!decoded_ret) begin
                        w_fault_nxt = 1'b1;
                        w_code_nxt  = 2'd1;
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                    if (w_mixed) begin
                        w_push     = 1'b1;
                        w_mask_nxt = w_taken;
                        w_pc_nxt   = w_new_pc;
                    end else if (r_sp != '0 && w_new_pc == w_tos.reconv_pc) begin
                        // First arrival switches to the pending lanes; second arrival rejoins them.
                        if (!w_tos.phase) begin
                            w_pc_nxt    = w_tos.pending_pc;
                            w_mask_nxt  = w_tos.pending_mask;
                            w_set_phase = 1'b1;
                        end else begin
                            w_pc_nxt   = w_new_pc;
                            w_mask_nxt = w_tos.full_mask;
                            w_pop      = 1'b1;
                        end
                    end else begin
                        w_pc_nxt = w_new_pc;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_mask        <= '0;
            r_launch_mask <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= 2'd0;
            r_sp          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_mask        <= w_mask_nxt;
            r_launch_mask <= w_launch_nxt;
            r_done        <= w_done_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_code  <= w_code_nxt;
            if (w_push)     r_sp <= r_sp + 1'b1;
            else if (w_pop) r_sp <= r_sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push)           r_stack[r_sp[IDXW-1:0]] <= w_push_ent;
        else if (reset && w_set_phase) r_stack[w_tos_idx[IDXW-1:0]].phase <= 1'b1;
    end

`ifdef SCHED_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_div;
    always_ff @(posedge clk) begin
        if (!reset || w_start_acc) begin
            r_perf_stall <= '0;
            r_perf_div   <= '0;
        end else begin
            if (r_state == S_WAIT && w_stall && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
            if (w_push && !(&r_perf_div))                         r_perf_div   <= r_perf_div + 1'b1;
        end
    end
    assign perf_stall_cycles = r_perf_stall;
    assign perf_divergences  = r_perf_div;
`else
    assign perf_stall_cycles = '0;
    assign perf_divergences  = '0;
`endif

    assign current_pc  = r_pc;
    assign active_mask = r_mask;
    assign core_state  = r_state;
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
endmodule

// File: doc/simt_warp_scheduler.md
Name: simt_warp_scheduler

Overview:
- Parametrised successor to the per-block core scheduler. Drives the same FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE pipeline as before.
- Runs one shared PC plus an active-thread mask, and handles divergence with an explicit reconvergence stack of {reconv_pc, pending_pc, pending_mask, full_mask, phase} entries.
- Adds partial-block launch, parametrised PC width and stack depth, barrier and stack fault detection, and optional performance counters.
- Sits between the fetcher/decoder and the per-thread ALU/LSU lanes of one core.

Parameters:
- THREADS_PER_BLOCK, 4, number of lanes (1..32).
- STACK_DEPTH, 8, number of reconvergence stack entries (>=1).
- PC_WIDTH, 8, program counter width.
- SPW = $clog2(STACK_DEPTH+1), derived (localparam), width of the stack pointer.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch pulse; sampled only in IDLE.
- thread_count  in  $clog2(THREADS_PER_BLOCK+1)  lanes enabled for this launch.
- decoded_mem_read_enable  in  1  current instruction reads memory.
- decoded_mem_write_enable  in  1  current instruction writes memory.
- decoded_ret  in  1  current instruction is RET.
- decoded_pc_mux  in  1  current instruction is a conditional branch.
- decoded_barrier_enable  in  1  current instruction is a barrier.
- decoded_nzp  in  3  branch condition mask.
- decoded_immediate  in  PC_WIDTH  branch target.
- decoded_reconv_pc  in  PC_WIDTH  immediate post-dominator of the branch.
- fetcher_state  in  3  value 3'b010 = instruction fetched.
- lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; 01 = requesting, 10 = waiting.
- alu_nzp  in  3*THREADS_PER_BLOCK  per-lane NZP flags, lane i at [3i+2:3i].
- next_pc  in  PC_WIDTH  current_pc+1 from the PC unit.
- current_pc  out  PC_WIDTH  shared warp PC.
- active_mask  out  THREADS_PER_BLOCK  lanes executing the current instruction.
- core_state  out  3  IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- done  out  1  kernel finished (normally or by fault); held until reset.
- fault  out  1  abnormal termination.
- fault_code  out  2  1 = stack overflow, 2 = diverged barrier, 3 = RET while diverged.
- perf_stall_cycles  out  32  see Optional Feature.
- perf_divergences  out  16  see Optional Feature.

Behaviour:

Reset (reset==0 at a clock edge):
- core_state=IDLE, current_pc=0, active_mask=0, done=0, fault=0, fault_code=0, sp=0, perf counters=0.
- Reset in any state aborts the kernel; the stack contents are don't-care.

IDLE:
- On start: launch_mask = low thread_count bits set. If thread_count > THREADS_PER_BLOCK, all lanes are enabled.
- thread_count==0: go to DONE, done=1, fault=0.
- Otherwise: active_mask=launch_mask, current_pc=0, go to FETCH.
- start is ignored in every other state.

Fixed transitions:
- FETCH -> DECODE when fetcher_state==3'b010; otherwise FETCH holds.
- DECODE -> REQUEST after 1 cycle.
- REQUEST -> WAIT after 1 cycle.

WAIT:
- Stalls while any lane with active_mask set has lsu_state 01 or 10. Inactive lanes are ignored.
- Barrier with active_mask != launch_mask: DONE, fault=1, fault_code=2.
- Otherwise, once the wait condition clears: EXECUTE.

EXECUTE -> UPDATE after 1 cycle.

UPDATE, resolved in this priority order:
1. RET
   - sp!=0: DONE, fault, code 3.
   - sp==0: DONE, done=1.
2. Branch (decoded_pc_mux): per lane, taken[i] = active[i] && (alu_nzp_i & decoded_nzp)!=0.
   - taken==0: new_pc = next_pc.
   - taken==active: new_pc = decoded_immediate.
   - Mixed, sp==STACK_DEPTH: DONE, fault, code 1.
   - Mixed, otherwise: push {decoded_reconv_pc, next_pc, active&~taken, active, phase 0}, active_mask=taken, new_pc=decoded_immediate.
3. Otherwise: new_pc = next_pc.

Reconvergence check on new_pc, applied in the same cycle:
- If sp>0 and new_pc == TOS.reconv_pc:
  - phase 0: current_pc=TOS.pending_pc, active_mask=TOS.pending_mask, TOS.phase=1.
  - phase 1: pop, active_mask=TOS.full_mask, current_pc=reconv_pc.
- Else current_pc=new_pc.
- At most one stack action per UPDATE.
- A reconvergence PC equal to a nested entry's PC is resolved one level per instruction pass.
- Then go to FETCH.

Other rules:
- Stack push and pop are never simultaneous.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- DONE is terminal until reset.

Optional Feature:
Macro SCHED_PERF_EN.
- Defined:
  - perf_stall_cycles increments each cycle spent in WAIT with a stall condition true, saturating at all-ones.
  - perf_divergences increments on each push, saturating.
  - Both are cleared on reset and on an accepted start.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Uniform run, THREADS_PER_BLOCK=4, thread_count=4, program of 3 ALU ops + RET, fetcher acknowledges immediately -> current_pc 0,1,2,3, done=1, fault=0, active_mask=4'hF throughout.
- Divergence at pc 2, lanes 0,1 taken, target 8, reconv 5 ->
  - lanes {0,1} execute pc 8 with active_mask=4'b0011, through to reaching pc 5;
  - then {2,3} execute pc 3..4 with 4'b1100;
  - then pc 5 with 4'hF, sp back to 0.
- Nested divergence STACK_DEPTH=1 -> second mixed branch gives done=1, fault=1, fault_code=1; core_state=7.
- thread_count=3, lane 3 lsu_state held 01 -> no stall (lane inactive); lane 1 held 10 for 5 cycles -> WAIT lasts 5 cycles; with SCHED_PERF_EN, perf_stall_cycles=5.
- Barrier inside a diverged path -> fault_code=2; RET with sp=1 -> fault_code=3.
- reset low during WAIT -> next cycle core_state=0, current_pc=0, active_mask=0; a following start relaunches cleanly.
